// File: rtl/tft_timing_pkg.sv
// Shared TFT panel timing constants and receiver state encoding.
// Values match the tft_driver that sources the interface.
package tft_timing_pkg;

  localparam int H_ACTIVE  = 480;
  localparam int V_ACTIVE  = 272;
  localparam int H_TOTAL   = 525;
  localparam int V_TOTAL   = 288;
  localparam int CNT_W     = 14;
  localparam int LINE_GAP  = H_TOTAL;
  localparam int FRAME_GAP = H_TOTAL * (V_TOTAL - V_ACTIVE + 1);

  typedef enum logic [1:0] {
    SEEK,
    ACTIVE,
    BLANK
  } rx_state_e;

endpackage

// File: rtl/tft_rx_sync.sv
// Two-flop synchronizer for the TFT bundle plus pixel-clock edge detect.
// Clock, enable and RGB share one chain so they stay aligned.
module tft_rx_sync (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tft_clk,
  input  logic        tft_data_ena,
  input  logic [23:0] tft_rgb,
  output logic        pclk_evt,
  output logic        ena_s,
  output logic [23:0] rgb_s
);

  logic [25:0] s1;
  logic [25:0] s2;
  logic        prev_clk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1       <= '0;
      s2       <= '0;
      prev_clk <= 1'b0;
    end else begin
      s1       <= {tft_clk, tft_data_ena, tft_rgb};
      s2       <= s1;
      prev_clk <= s2[25];
    end
  end

  assign pclk_evt = s2[25] & ~prev_clk;
  assign ena_s    = s2[24];
  assign rgb_s    = s2[23:0];

endmodule

// File: rtl/tft_rx_monitor.sv
// Panel-side TFT receiver: rebuilds pixel coordinates from the RGB
// interface and checks line/frame timing against the panel geometry.
module tft_rx_monitor #(
  parameter int H_ACTIVE = tft_timing_pkg::H_ACTIVE,
  parameter int V_ACTIVE = tft_timing_pkg::V_ACTIVE,
  parameter int H_TOTAL  = tft_timing_pkg::H_TOTAL,
  parameter int V_TOTAL  = tft_timing_pkg::V_TOTAL,
  parameter int CNT_W    = tft_timing_pkg::CNT_W
) (
  input  logic        cclk,
  input  logic        rstb,
  input  logic        tft_clk,
  input  logic        tft_data_ena,
  input  logic [7:0]  tft_red,
  input  logic [7:0]  tft_green,
  input  logic [7:0]  tft_blue,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [8:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic        frame_done,
  output logic        locked,
  output logic        timing_err,
  output logic [7:0]  err_count,
  output logic [15:0] frame_count
);
  import tft_timing_pkg::*;

  localparam int FG = H_TOTAL * (V_TOTAL - V_ACTIVE + 1);
  localparam logic [CNT_W-1:0] LINE_GAP_C  = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] FRAME_GAP_C = CNT_W'(FG);
  localparam logic [CNT_W-1:0] TMO_C       = CNT_W'(FG + 1);
  localparam logic [CNT_W-1:0] H_ACT_C     = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] ONE_C       = CNT_W'(1);
  localparam logic [9:0]       H_ACT_X     = 10'(H_ACTIVE);
  localparam logic [8:0]       V_LAST      = 9'(V_ACTIVE - 1);

  logic        pclk_evt;
  logic        ena_s;
  logic [23:0] rgb_s;

  tft_rx_sync u_sync (
    .clk          (cclk),
    .rst_n        (rstb),
    .tft_clk      (tft_clk),
    .tft_data_ena (tft_data_ena),
    .tft_rgb      ({tft_red, tft_green, tft_blue}),
    .pclk_evt     (pclk_evt),
    .ena_s        (ena_s),
    .rgb_s        (rgb_s)
  );

  rx_state_e        state, state_n;
  logic [9:0]       x, x_n;
  logic [8:0]       y, y_n;
  logic [CNT_W-1:0] gap, gap_n, gap_inc;
  logic [CNT_W-1:0] hlen, hlen_n;
  logic             ena_prev, ena_prev_n;
  logic             rise;
  logic             emit, err, done;

  assign rise    = ena_s & ~ena_prev;
  assign gap_inc = (&gap) ? gap : gap + ONE_C;
  assign locked  = (state != SEEK);

  always_comb begin
    state_n    = state;
    x_n        = x;
    y_n        = y;
    gap_n      = gap;
    hlen_n     = hlen;
    ena_prev_n = ena_prev;
    emit       = 1'b0;
    err        = 1'b0;
    done       = 1'b0;
    if (pclk_evt) begin
      ena_prev_n = ena_s;
      gap_n      = rise ? '0 : gap_inc;
      if (rise)       hlen_n = ONE_C;
      else if (ena_s) hlen_n = hlen + ONE_C;
      unique case (state)
        SEEK: begin
          if (rise && gap_inc == FRAME_GAP_C) begin
            state_n = ACTIVE;
            y_n     = '0;
            x_n     = 10'd1;
            emit    = 1'b1;
          end
        end
        ACTIVE: begin
          if (ena_s) begin
            if (x == H_ACT_X) begin
              err = 1'b1;
            end else begin
              x_n  = x + 10'd1;
              emit = 1'b1;
            end
          end else if (hlen != H_ACT_C) begin
            err = 1'b1;
          end else begin
            state_n = BLANK;
            done    = (y == V_LAST);
          end
        end
        BLANK: begin
          if (rise) begin
            if (gap_inc == LINE_GAP_C && y < V_LAST) begin
              y_n     = y + 9'd1;
              x_n     = 10'd1;
              state_n = ACTIVE;
              emit    = 1'b1;
            end else if (gap_inc == FRAME_GAP_C && y == V_LAST) begin
              y_n     = '0;
              x_n     = 10'd1;
              state_n = ACTIVE;
              emit    = 1'b1;
            end else begin
              err = 1'b1;
            end
          end else if (gap_inc == TMO_C) begin
            err = 1'b1;
          end
        end
        default: state_n = SEEK;
      endcase
      // an error on the same event suppresses the pixel
      if (err) begin
        state_n = SEEK;
        emit    = 1'b0;
      end
    end
  end

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state       <= SEEK;
      x           <= '0;
      y           <= '0;
      gap         <= '0;
      hlen        <= '0;
      ena_prev    <= 1'b0;
      pix_valid   <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      frame_done  <= 1'b0;
      timing_err  <= 1'b0;
      err_count   <= '0;
      frame_count <= '0;
    end else begin
      state      <= state_n;
      x          <= x_n;
      y          <= y_n;
      gap        <= gap_n;
      hlen       <= hlen_n;
      ena_prev   <= ena_prev_n;
      pix_valid  <= emit;
      frame_done <= done;
      timing_err <= err;
      if (emit) begin
        pix_x   <= x_n - 10'd1;
        pix_y   <= y_n;
        pix_rgb <= rgb_s;
      end
      if (done) frame_count <= frame_count + 16'd1;
      if (err && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_tft_rx_monitor.sv
// Scoreboard bench for tft_rx_monitor on a reduced panel geometry.
// Frames are generated in-bench; expected pixels are queued as driven.
module tb_tft_rx_monitor;

  localparam int HA = 4;
  localparam int VA = 3;
  localparam int HT = 6;
  localparam int VT = 5;
  localparam int CW = 14;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [23:0] rgb;
  } pix_t;

  logic        cclk = 1'b0;
  logic        rstb = 1'b0;
  logic        tft_clk = 1'b1;
  logic        tft_data_ena = 1'b0;
  logic [7:0]  tft_red = '0;
  logic [7:0]  tft_green = '0;
  logic [7:0]  tft_blue = '0;
  logic        pix_valid;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic [23:0] pix_rgb;
  logic        frame_done;
  logic        locked;
  logic        timing_err;
  logic [7:0]  err_count;
  logic [15:0] frame_count;

  tft_rx_monitor #(
    .H_ACTIVE (HA),
    .V_ACTIVE (VA),
    .H_TOTAL  (HT),
    .V_TOTAL  (VT),
    .CNT_W    (CW)
  ) dut (
    .cclk         (cclk),
    .rstb         (rstb),
    .tft_clk      (tft_clk),
    .tft_data_ena (tft_data_ena),
    .tft_red      (tft_red),
    .tft_green    (tft_green),
    .tft_blue     (tft_blue),
    .pix_valid    (pix_valid),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .pix_rgb      (pix_rgb),
    .frame_done   (frame_done),
    .locked       (locked),
    .timing_err   (timing_err),
    .err_count    (err_count),
    .frame_count  (frame_count)
  );

  always #5 cclk = ~cclk;

  int   n_chk = 0;
  int   n_fail = 0;
  pix_t exp_q[$];
  int   pix_seen = 0;
  int   fd_pulses = 0;
  int   err_pulses = 0;
  pix_t last_pix = '0;
  int   exp_fc = 0;
  int   exp_ec = 0;
  int   exp_fd = 0;
  int   exp_ep = 0;

  always @(negedge cclk) begin
    pix_t e;
    if (pix_valid) begin
      pix_seen++;
      last_pix = '{pix_x, pix_y, pix_rgb};
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pixel: got x=%0d y=%0d rgb=%h, required no pulse",
                 pix_x, pix_y, pix_rgb);
      end else begin
        e = exp_q.pop_front();
        if ({pix_x, pix_y, pix_rgb} !== e) begin
          n_fail++;
          $display("FAIL pixel: got x=%0d y=%0d rgb=%h, required x=%0d y=%0d rgb=%h",
                   pix_x, pix_y, pix_rgb, e.x, e.y, e.rgb);
        end
      end
    end
    if (frame_done) fd_pulses++;
    if (timing_err) err_pulses++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pclk(input logic ena, input logic [23:0] rgb);
    @(negedge cclk);
    tft_clk = 1'b0;
    tft_data_ena = ena;
    {tft_red, tft_green, tft_blue} = rgb;
    @(negedge cclk);
    @(negedge cclk);
    tft_clk = 1'b1;
    @(negedge cclk);
  endtask

  task automatic send_frame(input int short_line, input bit lock,
                            input int rst_line);
    for (int ln = 0; ln < VT; ln++) begin
      for (int px = 0; px < HT; px++) begin
        int          len;
        logic        ena;
        logic [23:0] rgb;
        if (ln == rst_line && px == 0) begin
          @(negedge cclk);
          rstb = 1'b0;
          #1;
          for (int i = 0; i < 3; i++) begin
            n_chk++;
            if ({pix_valid, frame_done, locked, timing_err, pix_x, pix_y,
                 pix_rgb, err_count, frame_count} !== '0) begin
              n_fail++;
              $display("FAIL reset_outputs: got v=%b fd=%b lk=%b te=%b x=%0d y=%0d rgb=%h ec=%0d fc=%0d, required all 0",
                       pix_valid, frame_done, locked, timing_err, pix_x,
                       pix_y, pix_rgb, err_count, frame_count);
            end
            @(negedge cclk);
          end
          rstb = 1'b1;
          exp_fc = 0;
          exp_ec = 0;
        end
        len = (ln == short_line) ? HA - 1 : HA;
        ena = (ln < VA) && (px < len);
        rgb = {8'(px), 8'(ln), 8'hA5};
        if (ena && lock && (short_line < 0 || ln <= short_line)
            && !(rst_line >= 0 && ln >= rst_line))
          exp_q.push_back('{10'(px), 9'(ln), rgb});
        pclk(ena, rgb);
      end
    end
  endtask

  task automatic test_reset;
    rstb = 1'b0;
    repeat (3) @(negedge cclk);
    n_chk++;
    if ({pix_valid, frame_done, locked, timing_err} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_flags: got %b, required 0000",
               {pix_valid, frame_done, locked, timing_err});
    end
    n_chk++;
    if ({pix_x, pix_y, pix_rgb} !== '0) begin
      n_fail++;
      $display("FAIL reset_pixel: got x=%0d y=%0d rgb=%h, required 0",
               pix_x, pix_y, pix_rgb);
    end
    n_chk++;
    if ({err_count, frame_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_counts: got ec=%0d fc=%0d, required 0",
               err_count, frame_count);
    end
    rstb = 1'b1;
  endtask

  task automatic test_loopback;
    send_frame(-1, 1'b0, -1);
    n_chk++;
    if (pix_seen !== 0 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL seek_frame: got pixels=%0d locked=%b, required 0 0",
               pix_seen, locked);
    end
    send_frame(-1, 1'b1, -1);
    send_frame(-1, 1'b1, -1);
    exp_fc = 2;
    exp_fd = 2;
    n_chk++;
    if (frame_count !== 16'(exp_fc) || err_count !== 8'(exp_ec)) begin
      n_fail++;
      $display("FAIL loopback_counts: got fc=%0d ec=%0d, required %0d %0d",
               frame_count, err_count, exp_fc, exp_ec);
    end
    n_chk++;
    if (pix_seen !== 2 * HA * VA || fd_pulses !== exp_fd || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL loopback_pulses: got pix=%0d fd=%0d lk=%b, required %0d %0d 1",
               pix_seen, fd_pulses, locked, 2 * HA * VA, exp_fd);
    end
  endtask

  task automatic test_pixel_ramp;
    pix_t want;
    send_frame(-1, 1'b1, -1);
    exp_fc++;
    exp_fd++;
    want = '{10'(HA - 1), 9'(VA - 1), {8'(HA - 1), 8'(VA - 1), 8'hA5}};
    n_chk++;
    if (last_pix !== want) begin
      n_fail++;
      $display("FAIL ramp_last_pixel: got %h, required %h", last_pix, want);
    end
    n_chk++;
    if (frame_count !== 16'(exp_fc) || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL ramp_frame: got fc=%0d pending=%0d, required %0d 0",
               frame_count, exp_q.size(), exp_fc);
    end
  endtask

  task automatic test_short_line;
    send_frame(1, 1'b1, -1);
    exp_ec++;
    exp_ep++;
    n_chk++;
    if (err_pulses !== exp_ep || err_count !== 8'(exp_ec) || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL short_line_err: got pulses=%0d ec=%0d lk=%b, required %0d %0d 0",
               err_pulses, err_count, locked, exp_ep, exp_ec);
    end
    n_chk++;
    if (frame_count !== 16'(exp_fc) || fd_pulses !== exp_fd) begin
      n_fail++;
      $display("FAIL short_line_no_done: got fc=%0d fd=%0d, required %0d %0d",
               frame_count, fd_pulses, exp_fc, exp_fd);
    end
    send_frame(-1, 1'b1, -1);
    exp_fc++;
    exp_fd++;
    n_chk++;
    if (frame_count !== 16'(exp_fc) || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL short_line_relock: got fc=%0d lk=%b, required %0d 1",
               frame_count, locked, exp_fc);
    end
  endtask

  task automatic test_clock_stall;
    send_frame(-1, 1'b1, -1);
    exp_fc++;
    exp_fd++;
    repeat (20000) @(negedge cclk);
    n_chk++;
    if (err_pulses !== exp_ep || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_no_err: got pulses=%0d lk=%b, required %0d 1",
               err_pulses, locked, exp_ep);
    end
    repeat (3) pclk(1'b0, 24'h0);
    exp_ec++;
    exp_ep++;
    n_chk++;
    if (err_pulses !== exp_ep || err_count !== 8'(exp_ec) || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_timeout: got pulses=%0d ec=%0d lk=%b, required %0d %0d 0",
               err_pulses, err_count, locked, exp_ep, exp_ec);
    end
    send_frame(-1, 1'b0, -1);
    send_frame(-1, 1'b1, -1);
    exp_fc++;
    exp_fd++;
    n_chk++;
    if (frame_count !== 16'(exp_fc) || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_relock: got fc=%0d lk=%b, required %0d 1",
               frame_count, locked, exp_fc);
    end
  endtask

  task automatic test_reset_midframe;
    send_frame(-1, 1'b1, 1);
    n_chk++;
    if (frame_count !== 16'(exp_fc) || err_count !== 8'(exp_ec)
        || fd_pulses !== exp_fd) begin
      n_fail++;
      $display("FAIL midreset_counts: got fc=%0d ec=%0d fd=%0d, required %0d %0d %0d",
               frame_count, err_count, fd_pulses, exp_fc, exp_ec, exp_fd);
    end
    send_frame(-1, 1'b1, -1);
    exp_fc++;
    exp_fd++;
    n_chk++;
    if (frame_count !== 16'(exp_fc) || locked !== 1'b1 || err_count !== 8'(exp_ec)) begin
      n_fail++;
      $display("FAIL midreset_relock: got fc=%0d lk=%b ec=%0d, required %0d 1 %0d",
               frame_count, locked, err_count, exp_fc, exp_ec);
    end
  endtask

  task automatic test_err_saturation;
    for (int f = 0; f < 300; f++) send_frame(0, 1'b1, -1);
    exp_ep += 300;
    exp_ec = (exp_ec + 300 > 255) ? 255 : exp_ec + 300;
    n_chk++;
    if (err_count !== 8'(exp_ec) || err_pulses !== exp_ep || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL err_saturate: got ec=%0d pulses=%0d lk=%b, required %0d %0d 0",
               err_count, err_pulses, locked, exp_ec, exp_ep);
    end
    send_frame(-1, 1'b1, -1);
    exp_fc++;
    exp_fd++;
    n_chk++;
    if (frame_count !== 16'(exp_fc) || fd_pulses !== exp_fd
        || err_count !== 8'(exp_ec)) begin
      n_fail++;
      $display("FAIL sat_clean_frame: got fc=%0d fd=%0d ec=%0d, required %0d %0d %0d",
               frame_count, fd_pulses, err_count, exp_fc, exp_fd, exp_ec);
    end
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_pixel_ramp();
    test_short_line();
    test_clock_stall();
    test_reset_midframe();
    test_err_saturation();
    n_chk++;
    if (exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pixels pending, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
